// File: rtl/adder_pkg.sv
// Shared types, defaults and configuration checks for the segmented carry-pipelined adder.
package adder_pkg;

   // Default geometry: 16-bit datapath resolved 4 bits per stage.
   localparam int DEF_WIDTH = 16;
   localparam int DEF_SEG   = 4;

   // Per-stage control that travels with each operation. The data part of
   // stage_t (partial sum, skewed operands) depends on WIDTH, so it is
   // declared next to the parameters inside the top module.
   typedef struct packed {
      logic valid;   // stage holds a live operation
      logic sub;     // operation was accepted as A - B
      logic carry;   // carry out of the segment resolved by this stage
   } stage_ctrl_t;

   // True when SEG is positive and divides WIDTH exactly.
   function automatic bit seg_divides(input int width, input int seg);
      return (seg > 0) && (width >= seg) && ((width % seg) == 0);
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders and an OR of their carries.
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   logic w_s0;
   logic w_c0;
   logic w_c1;

   half_adder u_ha_ab (
      .i_a     (i_a),
      .i_b     (i_b),
      .o_sum   (w_s0),
      .o_carry (w_c0)
   );

   half_adder u_ha_cin (
      .i_a     (w_s0),
      .i_b     (i_cin),
      .o_sum   (o_sum),
      .o_carry (w_c1)
   );

   // Both half-adder carries can never be 1 together, so OR equals the sum of carries.
   assign o_cout = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: sum = a ^ b, carry = a & b.
module half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_sum,
   output logic o_carry
);

   assign o_sum   = i_a ^ i_b;
   assign o_carry = i_a & i_b;

endmodule

// File: rtl/ripple_segment.sv
// Combinational SEG-bit ripple-carry segment. Also exposes the carry into its
// top bit so the final stage can derive two's-complement overflow.
module ripple_segment #(
   parameter int SEG = 4
) (
   input  logic [SEG-1:0] i_a,
   input  logic [SEG-1:0] i_b,
   input  logic           i_cin,
   output logic [SEG-1:0] o_sum,
   output logic           o_cout,
   output logic           o_c_msb
);

   logic [SEG:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < SEG; g++) begin : g_bit
      full_adder u_fa (
         .i_a    (i_a[g]),
         .i_b    (i_b[g]),
         .i_cin  (w_c[g]),
         .o_sum  (o_sum[g]),
         .o_cout (w_c[g+1])
      );
   end

   assign o_cout  = w_c[SEG];
   assign o_c_msb = w_c[SEG-1];

endmodule

// File: rtl/pipelined_segment_adder.sv
// WIDTH-bit add/subtract unit, carry-pipelined as STAGES = WIDTH/SEG ripple
// segments with a registered carry between them. One operation per cycle in,
// results out through a valid/ready stream; the whole pipe stalls as one.
module pipelined_segment_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG   = DEF_SEG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int STAGES = (SEG > 0) ? (WIDTH / SEG) : 1;

   if (!seg_divides(WIDTH, SEG)) begin : g_bad_cfg
      $error("pipelined_segment_adder: WIDTH (%0d) must be a positive multiple of SEG (%0d)",
             WIDTH, SEG);
   end

   // Everything one stage register holds. Operands and the partial sum keep
   // their natural bit positions: stage k reads segment k of the operands and
   // ORs its result into segment k of the sum, leaving lower segments untouched.
   typedef struct packed {
      stage_ctrl_t      ctrl;
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;   // already inverted for subtraction
   } stage_t;

   stage_t r_pipe [STAGES];   // r_pipe[k] = state after stage k resolved its segment
   stage_t w_src  [STAGES];   // what stage k consumes this cycle
   stage_t w_next [STAGES];   // what stage k will register on advance
   stage_t w_src0;            // operation as offered at the input

   logic   w_seg_cout  [STAGES];
   logic   w_seg_c_msb [STAGES];
   logic   w_last_ovf;
   logic   r_out_ovf;
   logic   w_adv;

   // Global advance: the pipe moves whenever the output slot is empty or being drained.
   assign w_adv    = ~r_pipe[STAGES-1].ctrl.valid | out_ready;
   assign in_ready = w_adv;

   // Capture the offered operation: subtraction inverts B and forces carry-in to 1.
   always_comb begin
      // NOTE: default the whole struct first so no path through this block can infer a latch.
      w_src0            = '0;
      w_src0.ctrl.valid = in_valid;
      w_src0.ctrl.sub   = in_sub;
      w_src0.ctrl.carry = in_sub | in_cin;
      w_src0.a          = in_a;
      w_src0.b          = in_sub ? ~in_b : in_b;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SEG-1:0] w_seg_sum;

      if (k == 0) begin : g_head
         assign w_src[k] = w_src0;
      end else begin : g_link
         assign w_src[k] = r_pipe[k-1];
      end

      ripple_segment #(
         .SEG (SEG)
      ) u_seg (
         .i_a     (w_src[k].a[k*SEG +: SEG]),
         .i_b     (w_src[k].b[k*SEG +: SEG]),
         .i_cin   (w_src[k].ctrl.carry),
         .o_sum   (w_seg_sum),
         .o_cout  (w_seg_cout[k]),
         .o_c_msb (w_seg_c_msb[k])
      );

      assign w_next[k].ctrl.valid = w_src[k].ctrl.valid;
      assign w_next[k].ctrl.sub   = w_src[k].ctrl.sub;
      assign w_next[k].ctrl.carry = w_seg_cout[k];
      assign w_next[k].sum        = w_src[k].sum | (WIDTH'(w_seg_sum) << (k * SEG));
      assign w_next[k].a          = w_src[k].a;
      assign w_next[k].b          = w_src[k].b;

      // Overflow only makes sense once the MSB segment has been resolved.
      if (k == STAGES - 1) begin : g_ovf
         assign w_last_ovf = w_seg_c_msb[k] ^ w_seg_cout[k];
      end
   end

   // Shift all stages together; data fields load only for live operations so the
   // outputs keep their last value while bubbles pass through.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: data fields are cleared too, not just valids, so outputs read 0 right after reset.
         for (int k = 0; k < STAGES; k++) begin
            r_pipe[k] <= '0;
         end
         r_out_ovf <= 1'b0;
      end else if (w_adv) begin
         // NOTE: sequential state is written with non-blocking assignments only, so every
         // stage samples its neighbour's pre-edge value regardless of loop order.
         for (int k = 0; k < STAGES; k++) begin
            if (w_next[k].ctrl.valid) begin
               r_pipe[k] <= w_next[k];
            end else begin
               r_pipe[k].ctrl.valid <= 1'b0;
            end
         end
         if (w_next[STAGES-1].ctrl.valid) begin
            r_out_ovf <= w_last_ovf;
         end
      end
   end

   assign out_valid = r_pipe[STAGES-1].ctrl.valid;
   assign out_sum   = r_pipe[STAGES-1].sum;
   assign out_cout  = r_pipe[STAGES-1].ctrl.carry;
   assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Scoreboard bench for pipelined_segment_adder (WIDTH=16, SEG=4, latency 4).
// The driver pushes expected results at acceptance; an independent monitor
// pops and compares whenever a result is handed over.
module tb_pipelined_segment_adder;

   localparam int W   = 16;
   localparam int SEG = 4;
   localparam int LAT = W / SEG;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;

   pipelined_segment_adder #(
      .WIDTH (W),
      .SEG   (SEG)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           acc;
      bit           chk_lat;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   exp_t exp_q [$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ready_mode = 0;   // 0: always ready, 1: random, 2: 3-cycle stall window
   int   stall_lo = 0;
   int   stall_seen = 0;

   vec_t dir_vec [5] = '{
      '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
      '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0},
      '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
      '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1}
   };

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cycle);
      end
   endtask

   // Reference: unsigned and signed integer arithmetic on the operands.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t e;
      int   ua = int'(a);
      int   ub = int'(b);
      int   sa = int'($signed(a));
      int   sb = int'($signed(b));
      int   ures;
      int   sres;
      if (sub) begin
         ures   = ua - ub;
         sres   = sa - sb;
         e.cout = (ua >= ub);
      end else begin
         ures   = ua + ub + int'(cin);
         sres   = sa + sb + int'(cin);
         e.cout = (ures >= (1 << W));
      end
      e.sum     = ures[W-1:0];
      e.ovf     = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
      e.acc     = 0;
      e.chk_lat = 1'b0;
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         default: return W'($urandom);
      endcase
   endfunction

   // Offer one operation and hold it until accepted; push its expected result on acceptance.
   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input exp_t e);
      int waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_sub   = sub;
      #1;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (in_ready) begin
         e.acc = cycle;
         exp_q.push_back(e);
      end else begin
         check("accept_timeout", in_ready, 1);
      end
   endtask

   task automatic send_rand(input bit chk_lat);
      logic [W-1:0] a = pick();
      logic [W-1:0] b = pick();
      logic         cin = 1'($urandom);
      logic         sub = 1'($urandom);
      exp_t         e = model(a, b, cin, sub);
      e.chk_lat = chk_lat;
      send_op(a, b, cin, sub, e);
   endtask

   // One bubble cycle with junk data on the operand lines.
   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_cin   = 1'($urandom);
      in_sub   = 1'($urandom);
   endtask

   task automatic drain();
      int waited = 0;
      idle();
      while (exp_q.size() != 0 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
   endtask

   // Consumer side: drives out_ready according to the current mode.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = !(cycle >= stall_lo && cycle < stall_lo + 3);
         endcase
      end
   end

   // Monitor: handshake rule, output stability, and scoreboard comparison.
   bit           have_prev = 0;
   logic         prev_valid;
   logic         prev_ready;
   logic [W-1:0] prev_sum;
   logic         prev_cout;
   logic         prev_ovf;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            have_prev = 0;
         end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (have_prev) begin
               if (prev_valid && !prev_ready) begin
                  check("stall_hold", {out_valid, out_cout, out_ovf, out_sum},
                        {1'b1, prev_cout, prev_ovf, prev_sum});
               end else if (!out_valid) begin
                  check("bubble_hold", {out_cout, out_ovf, out_sum},
                        {prev_cout, prev_ovf, prev_sum});
               end
            end
            if (out_valid && !out_ready && !in_ready) stall_seen++;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out", out_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("sum", out_sum, e.sum);
                  check("cout", out_cout, e.cout);
                  check("ovf", out_ovf, e.ovf);
                  if (e.chk_lat) check("latency", cycle - e.acc, LAT);
               end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_sum   = out_sum;
            prev_cout  = out_cout;
            prev_ovf   = out_ovf;
            have_prev  = 1;
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cycle);
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_cin   = 1'b0;
      in_sub   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_cout", out_cout, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_in_ready", in_ready, 1);

      // Directed corner vectors, back-to-back, with exact latency.
      foreach (dir_vec[i]) begin
         e.sum     = dir_vec[i].sum;
         e.cout    = dir_vec[i].cout;
         e.ovf     = dir_vec[i].ovf;
         e.chk_lat = 1'b1;
         send_op(dir_vec[i].a, dir_vec[i].b, dir_vec[i].cin, dir_vec[i].sub, e);
      end
      drain();

      // Full-rate stream: every result must arrive exactly LAT cycles after acceptance.
      for (int i = 0; i < 20; i++) send_rand(1'b1);
      drain();

      // Eight back-to-back ops with a 3-cycle consumer stall once results flow.
      stall_seen = 0;
      send_rand(1'b0);
      stall_lo   = cycle + 6;
      ready_mode = 2;
      for (int i = 0; i < 7; i++) send_rand(1'b0);
      drain();
      check("stall_cycles", stall_seen, 3);
      ready_mode = 0;

      // Reset with three operations in flight: all of them must vanish.
      for (int i = 0; i < 3; i++) send_rand(1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_sum", out_sum, 0);
      check("midrst_out_cout", out_cout, 0);
      check("midrst_out_ovf", out_ovf, 0);
      repeat (8) idle();
      send_rand(1'b1);
      drain();

      // Long randomized run with input bubbles and random back-pressure.
      ready_mode = 1;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 4) == 0) idle();
         send_rand(1'b0);
      end
      drain();
      ready_mode = 0;
      repeat (2) idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
